// File: rtl/pdp8_decode_queue.sv
// PDP-8 decode stage: decodes each accepted instruction word into MRI,
// operate-group and IOT fields, then buffers the decoded entries in a
// DEPTH-entry FIFO with valid/ready handshakes on both sides and a flush.
module pdp8_decode_queue #(
  parameter int DEPTH     = 4,
  parameter int PAGE_BITS = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [11:0]                  in_inst,
  input  logic [11:0]                  in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [11:0]                  out_pc,
  output logic [5:0]                   out_mri,
  output logic                         out_indirect,
  output logic [11:0]                  out_addr,
  output logic                         out_iot,
  output logic                         out_g1,
  output logic [7:0]                   out_g1_uops,
  output logic                         out_g2,
  output logic [6:0]                   out_g2_uops,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [11:0] pc;
    logic [5:0]  mri;
    logic        indirect;
    logic [11:0] addr;
    logic        iot;
    logic        g1;
    logic [7:0]  g1_uops;
    logic        g2;
    logic [6:0]  g2_uops;
    logic        illegal;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_count;

  entry_t          w_dec;
  entry_t          w_head;
  logic [2:0]      w_op;
  logic            w_push;
  logic            w_pop;

  assign w_op      = in_inst[11:9];
  assign in_ready  = (r_count < CW'(DEPTH)) && !flush;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  // Decode the incoming word; fields not belonging to its class stay zero.
  always_comb begin
    w_dec    = '0;
    w_dec.pc = in_pc;
    case (w_op)
      3'd6: w_dec.iot = 1'b1;
      3'd7: begin
        if (!in_inst[8]) begin
          w_dec.g1      = 1'b1;
          w_dec.g1_uops = in_inst[7:0];
          // RAR and RAL together have no defined rotate meaning.
          w_dec.illegal = in_inst[3] && in_inst[2];
        end else if (!in_inst[0]) begin
          w_dec.g2      = 1'b1;
          w_dec.g2_uops = in_inst[7:1];
        end else begin
          // Group 3 encodings decode as illegal on this machine.
          w_dec.illegal = 1'b1;
        end
      end
      default: begin
        w_dec.mri[w_op]  = 1'b1;
        w_dec.indirect   = in_inst[8];
        w_dec.addr       = in_inst[7] ? {in_pc[11:PAGE_BITS], in_inst[PAGE_BITS-1:0]}
                                      : {{(12-PAGE_BITS){1'b0}}, in_inst[PAGE_BITS-1:0]};
      end
    endcase
  end

  // Entry storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= w_dec;
    end
  end

  // Pointer and occupancy bookkeeping with reset > flush > push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head       = r_mem[r_rd];
  assign out_pc       = w_head.pc;
  assign out_mri      = w_head.mri;
  assign out_indirect = w_head.indirect;
  assign out_addr     = w_head.addr;
  assign out_iot      = w_head.iot;
  assign out_g1       = w_head.g1;
  assign out_g1_uops  = w_head.g1_uops;
  assign out_g2       = w_head.g2;
  assign out_g2_uops  = w_head.g2_uops;
  assign out_illegal  = w_head.illegal;

endmodule

// File: tb/tb_pdp8_decode_queue.sv
// Bench for pdp8_decode_queue: literal decode table, full/wrap, flush and
// reset sequences, and random traffic against a queue-based model.
module tb_pdp8_decode_queue;

  localparam int DEPTH     = 4;
  localparam int PAGE_BITS = 7;

  logic        clk = 1'b0;
  logic        t_reset, t_flush, t_valid, t_ready;
  logic [11:0] t_inst, t_pc;
  logic        in_ready, out_valid, out_indirect, out_iot, out_g1, out_g2, out_illegal;
  logic [11:0] out_pc, out_addr;
  logic [5:0]  out_mri;
  logic [7:0]  out_g1_uops;
  logic [6:0]  out_g2_uops;
  logic [2:0]  count;
  logic [49:0] w_head;

  int n_checks = 0;
  int n_fail   = 0;
  logic [49:0] q[$];

  pdp8_decode_queue #(.DEPTH(DEPTH), .PAGE_BITS(PAGE_BITS)) dut (
    .clk(clk), .reset(t_reset), .flush(t_flush),
    .in_valid(t_valid), .in_ready(in_ready), .in_inst(t_inst), .in_pc(t_pc),
    .out_valid(out_valid), .out_ready(t_ready), .out_pc(out_pc), .out_mri(out_mri),
    .out_indirect(out_indirect), .out_addr(out_addr), .out_iot(out_iot),
    .out_g1(out_g1), .out_g1_uops(out_g1_uops), .out_g2(out_g2),
    .out_g2_uops(out_g2_uops), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  assign w_head = {out_pc, out_mri, out_indirect, out_addr, out_iot, out_g1,
                   out_g1_uops, out_g2, out_g2_uops, out_illegal};

  typedef struct {
    logic [11:0] inst;
    logic [11:0] pc;
    logic [5:0]  mri;
    logic        ind;
    logic [11:0] addr;
    logic        iot;
    logic        g1;
    logic [7:0]  g1u;
    logic        g2;
    logic [6:0]  g2u;
    logic        ill;
  } vec_t;

  vec_t vt[10];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decode from the instruction-set rules, using plain arithmetic.
  function automatic logic [49:0] ref_decode(int inst, int pc);
    int op, pg, off;
    logic [5:0]  mri;
    logic        ind, iot, g1, g2, ill;
    logic [11:0] addr;
    logic [7:0]  g1u;
    logic [6:0]  g2u;
    op = inst / 512; pg = 1 << PAGE_BITS; off = inst % pg;
    mri = '0; ind = 1'b0; iot = 1'b0; g1 = 1'b0; g2 = 1'b0; ill = 1'b0;
    addr = '0; g1u = '0; g2u = '0;
    if (op < 6) begin
      mri  = 6'(1 << op);
      ind  = ((inst / 256) % 2) == 1;
      addr = ((inst / 128) % 2) == 1 ? 12'((pc - pc % pg) + off) : 12'(off);
    end else if (op == 6) begin
      iot = 1'b1;
    end else if ((inst / 256) % 2 == 0) begin
      g1  = 1'b1;
      g1u = 8'(inst % 256);
      ill = ((inst / 8) % 2 == 1) && ((inst / 4) % 2 == 1);
    end else if (inst % 2 == 0) begin
      g2  = 1'b1;
      g2u = 7'((inst % 256) / 2);
    end else begin
      ill = 1'b1;
    end
    return {12'(pc), mri, ind, addr, iot, g1, g1u, g2, g2u, ill};
  endfunction

  task automatic check_state(string tag);
    #1;
    chk({tag, "_count"}, 64'(count), 64'(q.size()));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'((q.size() < DEPTH) && !t_flush));
    if (q.size() > 0) chk({tag, "_head"}, 64'(w_head), 64'(q[0]));
  endtask

  task automatic tick();
    logic push, pop;
    logic [49:0] d;
    push = t_valid && (q.size() < DEPTH) && !t_flush;
    pop  = t_ready && (q.size() > 0);
    d    = ref_decode(int'(t_inst), int'(t_pc));
    @(posedge clk);
    #1;
    if (t_reset || t_flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
  endtask

  initial begin
    logic [11:0] exp_pc[4];
    vt[0] = '{12'o1377, 12'o0200, 6'b000010, 1'b0, 12'o0377, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0};
    vt[1] = '{12'o5600, 12'o4321, 6'b100000, 1'b1, 12'o4200, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0};
    vt[2] = '{12'o7300, 12'o0010, 6'b000000, 1'b0, 12'o0000, 1'b0, 1'b1, 8'b11000000, 1'b0, 7'h00, 1'b0};
    vt[3] = '{12'o7450, 12'o0011, 6'b000000, 1'b0, 12'o0000, 1'b0, 1'b0, 8'h00, 1'b1, 7'b0010100, 1'b0};
    vt[4] = '{12'o7014, 12'o0012, 6'b000000, 1'b0, 12'o0000, 1'b0, 1'b1, 8'b00001100, 1'b0, 7'h00, 1'b1};
    vt[5] = '{12'o7401, 12'o0013, 6'b000000, 1'b0, 12'o0000, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b1};
    vt[6] = '{12'o6031, 12'o0014, 6'b000000, 1'b0, 12'o0000, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0};
    vt[7] = '{12'o2045, 12'o3777, 6'b000100, 1'b0, 12'o0045, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0};
    vt[8] = '{12'o3777, 12'o1234, 6'b001000, 1'b1, 12'o1377, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0};
    vt[9] = '{12'o4377, 12'o7777, 6'b010000, 1'b0, 12'o7777, 1'b0, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0};

    t_reset = 1'b1; t_flush = 1'b0; t_valid = 1'b0; t_ready = 1'b0;
    t_inst = '0; t_pc = '0;
    tick(); tick();
    t_reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Literal decode table, one entry through an empty queue at a time.
    for (int i = 0; i < 10; i++) begin
      t_valid = 1'b1; t_inst = vt[i].inst; t_pc = vt[i].pc; t_ready = 1'b0;
      tick();
      t_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_count", i), 64'(count), 64'd1);
      chk($sformatf("vec%0d_decode", i), 64'(w_head),
          64'({vt[i].pc, vt[i].mri, vt[i].ind, vt[i].addr, vt[i].iot, vt[i].g1,
               vt[i].g1u, vt[i].g2, vt[i].g2u, vt[i].ill}));
      t_ready = 1'b1;
      tick();
      t_ready = 1'b0;
    end

    // Fill past capacity, pop while full, then drain across pointer wrap.
    for (int i = 0; i < 5; i++) begin
      t_valid = 1'b1; t_inst = 12'(12'o7200 + i); t_pc = 12'(100 + i);
      check_state("fill");
      tick();
    end
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    t_ready = 1'b1;
    check_state("fullpop");
    tick();
    #1;
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_head_pc", 64'(out_pc), 64'd101);
    t_ready = 1'b0;
    tick();
    #1;
    chk("resume_count", 64'(count), 64'd4);
    exp_pc = '{12'd101, 12'd102, 12'd103, 12'd104};
    t_valid = 1'b0; t_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("drain%0d_pc", k), 64'(out_pc), 64'(exp_pc[k]));
      tick();
    end
    #1;
    chk("drain_count", 64'(count), 64'd0);
    t_ready = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 1000; c++) begin
      t_valid = ($urandom_range(0, 3) != 0);
      t_ready = ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 8));
      t_flush = ($urandom_range(0, 49) == 0);
      t_inst  = 12'($urandom);
      t_pc    = 12'($urandom);
      check_state("rnd");
      tick();
    end
    t_valid = 1'b0; t_ready = 1'b0; t_flush = 1'b0;
    t_reset = 1'b1; tick(); t_reset = 1'b0;

    // Flush with three entries held and a push presented in the same cycle.
    for (int i = 0; i < 3; i++) begin
      t_valid = 1'b1; t_inst = 12'o1000; t_pc = 12'(200 + i);
      tick();
    end
    #1;
    chk("preflush_count", 64'(count), 64'd3);
    t_flush = 1'b1; t_pc = 12'd203;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    t_flush = 1'b0; t_valid = 1'b0;
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    #1;
    chk("flush_absent_count", 64'(count), 64'd0);

    // Reset with two entries held.
    for (int i = 0; i < 2; i++) begin
      t_valid = 1'b1; t_inst = 12'o2000; t_pc = 12'(300 + i);
      tick();
    end
    t_valid = 1'b0;
    #1;
    chk("prereset_count", 64'(count), 64'd2);
    t_reset = 1'b1;
    tick();
    t_reset = 1'b0;
    #1;
    chk("midreset_count", 64'(count), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pdp8_decode_queue.md
# pdp8_decode_queue

Registered PDP-8 instruction decode stage with a parametrised decoded-instruction queue, sitting between instruction fetch and execute. Each accepted 12-bit instruction word is decoded into one-hot MRI flags, bit-level group 1 and group 2 operate micro-op flags, and an IOT flag. The decoder also computes the effective direct address and flags illegal encodings. Decoded entries are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides and a flush for control-flow redirects.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- PAGE_BITS, 7: in-page offset width. Address width is 12; the page number is pc[11:PAGE_BITS].
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discards all queued entries and any same-cycle push.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count < DEPTH) && !flush.
- in_inst  in  12  instruction word.
- in_pc  in  12  address of in_inst.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  execute consumes head.
- out_pc  out  12  PC of head entry.
- out_mri  out  6  one-hot {JMP,JMS,DCA,ISZ,TAD,AND} (bit0 = AND).
- out_indirect  out  1  MRI bit 8.
- out_addr  out  12  effective direct address; 0 for non-MRI.
- out_iot  out  1  opcode 6.
- out_g1  out  1  group 1 operate.
- out_g1_uops  out  8  {CLA,CLL,CMA,CML,RAR,RAL,BSW,IAC} = inst[7:0].
- out_g2  out  1  group 2 operate.
- out_g2_uops  out  7  {CLA,SMA,SZA,SNL,REV,OSR,HLT} = inst[7:1].
- out_illegal  out  1  illegal encoding.
- count  out  $clog2(DEPTH+1)  entries held.

## Operation
- Push: in_valid && in_ready at a rising edge. The decoded entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Full queue: in_ready = 0 even if out_ready = 1. There is no same-cycle pass-through.
- Decode, with op = in_inst[11:9]:
  - op 0–5 (MRI): out_mri[op] = 1; indirect = inst[8].
  - MRI address: addr = inst[7] ? {pc[11:PAGE_BITS], inst[PAGE_BITS-1:0]} : zero-extended offset.
  - op 6: out_iot = 1.
  - op 7, inst[8] = 0: group 1.
  - op 7, inst[8] = 1, inst[0] = 0: group 2.
  - op 7, inst[8] = 1, inst[0] = 1: group 3 (no EAE). Sets out_illegal, and out_g1 = out_g2 = 0.
  - Group 1 with RAR and RAL both set: sets out_illegal; out_g1 and out_g1_uops still reflect the encoding.
  - Unused output fields are 0 for every class.
- Flush: count, rd_ptr and wr_ptr become 0 at the edge. A push presented in the flush cycle is not accepted, because in_ready is 0.
- Priority: reset > flush > push/pop.
- Storage contents are not reset. All out_* decode fields are qualified only by out_valid.

## Timing
- Reset values: count = 0, out_valid = 0, in_ready = 1 (with flush low), and rd_ptr = wr_ptr = 0.
- Latency: instruction accepted at edge N gives out_valid = 1 after edge N, with its decode at the head if the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- in_ready depends only on registered count and flush. There is no combinational path from out_ready.
- Pointers wrap from DEPTH-1 to 0; count saturates nowhere because push is blocked at full.
- Reset mid-stream: all queued entries are lost; outputs take reset values the cycle after.

## Test plan
- Reset, then push inst 0o1377 with pc 0o0200 → next cycle: out_valid = 1, out_mri = 6'b000010, out_indirect = 0, out_addr = 0o0377, count = 1.
- Push inst 0o5600 with pc 0o4321 → out_mri = 6'b100000, out_indirect = 1, out_addr = 0o4200.
- Decode sweep of the operate and IOT encodings:
  - 0o7300 → out_g1 = 1, out_g1_uops = 8'b11000000.
  - 0o7450 → out_g2 = 1, out_g2_uops = 7'b0010100.
  - 0o7014 → out_g1 = 1, out_illegal = 1.
  - 0o7401 → out_illegal = 1, out_g1 = out_g2 = 0.
  - 0o6031 → out_iot = 1, out_addr = 0.
- Hold out_ready = 0 and push 5 entries with DEPTH = 4 → the 4th push fills the queue; count = 4 and in_ready = 0. While full, assert out_ready with in_valid held → one pop and no push that cycle; push resumes next cycle. Drain order equals push order across pointer wrap.
- Random valid/ready traffic for 1000 cycles with scoreboard → no loss, duplication or reorder. count always matches pushes minus pops.
- Mid-stream events:
  - Assert flush with count = 3, in_valid = 1 → after the edge, count = 0 and out_valid = 0; the flush-cycle instruction is absent.
  - Assert reset with count = 2 → same result.
